// File: rtl/mio_bus_if.sv
// -----------------------------------------------------------------------------
// mio_bus_if
//
// Memory/IO bus interface sitting behind the SCPU control unit. One word access
// is accepted per request strobe. The address decides between RAM space and
// peripheral space (addr[31:28] = E or F). A small wait-state FSM sequences the
// access and returns a one-cycle MIO_ready pulse that lets control advance PC.
//
// Optional feature (compile-time macro MIO_TIMEOUT_EN):
//   When defined, a peripheral access that sees no io_ack within TIMEOUT cycles
//   is aborted: MIO_ready is pulsed together with bus_err, and reads return
//   32'hDEAD_BEEF. When undefined, peripheral accesses wait indefinitely for
//   io_ack and bus_err is tied low.
//
// Parameters
//   RAM_WAIT  RAM access cycles before completion (>= 1)
//   TIMEOUT   peripheral cycles without io_ack before abort (macro builds only)
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   CPU_MIO, WR           request strobe and write flag from control
//   cpu_addr, cpu_wdata   byte address (word access) and write data
//   cpu_rdata             read data, valid with MIO_ready, held until next read
//   MIO_ready             one-cycle completion pulse
//   ram_en/we/addr/wdata  RAM port (ram_addr is the word address addr[11:2])
//   ram_rdata             RAM read data
//   io_en/we/addr/wdata   peripheral port (io_addr is addr[5:2])
//   io_rdata, io_ack      peripheral read data and one-cycle completion
//   bus_err               timeout abort flag, coincident with MIO_ready
// -----------------------------------------------------------------------------
module mio_bus_if #(
  parameter int RAM_WAIT = 1,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        WR,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        MIO_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        io_en,
  output logic        io_we,
  output logic [3:0]  io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack,
  output logic        bus_err
);

  localparam int CNT_MAX = (RAM_WAIT > TIMEOUT) ? RAM_WAIT : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_ACC = 2'd1,
    IO_ACC  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         addr_q;     // word address addr[11:2]; io_addr is its low nibble
  logic [31:0]        wdata_q;
  logic               we_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;

  logic               is_io;
  logic               ram_last;
  logic               io_timeout;

  // Only the word-address bits within the RAM window are ever used.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, cpu_addr[27:12], cpu_addr[1:0]};

  assign is_io    = (cpu_addr[31:28] == 4'hE) || (cpu_addr[31:28] == 4'hF);
  assign ram_last = (cnt_q == CNT_W'(RAM_WAIT - 1));

`ifdef MIO_TIMEOUT_EN
  // An ack arriving on the expiring cycle takes priority over the abort.
  assign io_timeout = (cnt_q == CNT_W'(TIMEOUT - 1)) && !io_ack;
`else
  assign io_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (CPU_MIO) state_d = is_io ? IO_ACC : RAM_ACC;
      RAM_ACC: if (ram_last) state_d = DONE;
      IO_ACC:  if (io_ack || io_timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait counter and read-data return
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too because cpu_rdata and every
    // port derived from the captured request must read 0 out of reset.
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (CPU_MIO) begin
            addr_q  <= cpu_addr[11:2];
            wdata_q <= cpu_wdata;
            we_q    <= WR;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        RAM_ACC: begin
          cnt_q <= cnt_q + 1'b1;
          if (ram_last && !we_q) cpu_rdata <= ram_rdata;
        end
        IO_ACC: begin
`ifdef MIO_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          if (io_ack) begin
            if (!we_q) cpu_rdata <= io_rdata;
          end else if (io_timeout) begin
            err_q <= 1'b1;
            if (!we_q) cpu_rdata <= 32'hDEAD_BEEF;
          end
        end
        DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Port drive: strobes decode from the state, data comes from the capture.
  assign ram_en    = (state_q == RAM_ACC);
  assign ram_we    = ram_en && we_q && (cnt_q == '0);  // single write pulse
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign io_en     = (state_q == IO_ACC);
  assign io_we     = io_en && we_q;
  assign io_addr   = addr_q[3:0];
  assign io_wdata  = wdata_q;

  assign MIO_ready = (state_q == DONE);
`ifdef MIO_TIMEOUT_EN
  assign bus_err   = MIO_ready && err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_if.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_if
//
// Scoreboard bench for mio_bus_if. Each request pushes its expected read data,
// error flag and completion cycle; a monitor pops one entry per MIO_ready pulse.
// A behavioural RAM and a peripheral with programmable ack delay drive the
// slave-side inputs. Build with MIO_TIMEOUT_EN defined or not; expectations for
// the abort case follow the same macro.
// -----------------------------------------------------------------------------
module tb_mio_bus_if;

  localparam int RAM_WAIT = 1;
  localparam int TIMEOUT  = 16;
  localparam int RAM_LAT  = 1 + RAM_WAIT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CPU_MIO = 1'b0;
  logic        WR = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        MIO_ready;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        io_en, io_we;
  logic [3:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata = '0;
  logic        io_ack;
  logic        bus_err;

  mio_bus_if #(.RAM_WAIT(RAM_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .WR(WR),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .MIO_ready(MIO_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- RAM model: combinational lookup on the word address
  function automatic logic [31:0] ram_val(input logic [9:0] a);
    return (a == 10'd4) ? 32'h1234_5678 : {12'hB00, a, 10'h155};
  endfunction
  always_comb ram_rdata = ram_val(ram_addr);

  int          we_count = 0;
  logic [9:0]  last_ram_addr = '0;
  logic [9:0]  last_we_addr = '0;
  logic [31:0] last_ram_wdata = '0;
  always @(negedge clk) begin
    if (ram_en) last_ram_addr = ram_addr;
    if (ram_we) begin
      we_count++;
      last_we_addr   = ram_addr;
      last_ram_wdata = ram_wdata;
    end
  end

  // ---------------- Peripheral model: ack on the ack_delay-th io_en cycle
  int          ack_delay = 0;       // 0 = never acknowledge
  int          io_cnt = 0;
  int          last_io_len = 0;
  logic [3:0]  last_io_addr = '0;
  logic        io_we_seen = 1'b0;
  logic [31:0] last_io_wdata = '0;
  logic        model_ack = 1'b0;
  logic        stray_ack = 1'b0;
  assign io_ack = model_ack | stray_ack;

  always @(negedge clk) begin
    if (io_en) begin
      io_cnt++;
      last_io_addr = io_addr;
      if (io_we) begin
        io_we_seen    = 1'b1;
        last_io_wdata = io_wdata;
      end
      model_ack = (io_cnt == ack_delay);
    end else begin
      if (io_cnt != 0) last_io_len = io_cnt;
      io_cnt    = 0;
      model_ack = 1'b0;
    end
  end

  // ---------------- Scoreboard
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
  } exp_t;
  exp_t sb[$];
  int   ready_count = 0;

  always @(negedge clk) begin
    exp_t e;
    if (MIO_ready) begin
      ready_count++;
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("cpu_rdata", cpu_rdata, e.rdata);
        check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // ---------------- Stimulus helpers (inputs change 1 ns after the falling edge)
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int lat, input logic [31:0] rd, input logic err);
    exp_t e;
    e.rdata    = rd;
    e.err      = err;
    e.done_cyc = cyc + lat;
    sb.push_back(e);
  endtask

  // One-cycle request strobe; dropping CPU_MIO afterwards must not cancel it.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit push, input int lat, input logic [31:0] rd, input logic err);
    CPU_MIO   = 1'b1;
    WR        = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    if (push) push_exp(lat, rd, err);
    tick();
    CPU_MIO = 1'b0;
  endtask

  task automatic wait_ready(input int target, input int budget);
    for (int i = 0; i < budget && ready_count < target; i++) tick();
    check("ready_within_budget", 32'(ready_count >= target), 32'd1);
  endtask

  logic [31:0] model_rd = '0;
  int          n0;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_mio_ready", {31'd0, MIO_ready}, 32'd0);
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_io_en", {31'd0, io_en}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // RAM read at 0x10 -> word 4
    n0 = ready_count;
    do_req(1'b0, 32'h0000_0010, 32'h0, 1'b1, RAM_LAT, 32'h1234_5678, 1'b0);
    wait_ready(n0 + 1, 10);
    check("ram_rd_addr", {22'd0, last_ram_addr}, 32'd4);
    model_rd = 32'h1234_5678;
    tick();

    // RAM write at 0x20 -> exactly one write pulse, read data unchanged
    we_count = 0;
    n0 = ready_count;
    do_req(1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1, RAM_LAT, model_rd, 1'b0);
    wait_ready(n0 + 1, 10);
    tick();
    check("ram_we_pulses", 32'(we_count), 32'd1);
    check("ram_we_addr", {22'd0, last_we_addr}, 32'd8);
    check("ram_wdata", last_ram_wdata, 32'hA5A5_A5A5);

    // IO read 0xE000_0004, ack on third io_en cycle
    ack_delay = 3;
    io_rdata  = 32'h0000_CAFE;
    n0 = ready_count;
    do_req(1'b0, 32'hE000_0004, 32'h0, 1'b1, 1 + 3, 32'h0000_CAFE, 1'b0);
    wait_ready(n0 + 1, 10);
    check("io_rd_addr", {28'd0, last_io_addr}, 32'd1);
    check("io_en_cycles", 32'(last_io_len), 32'd3);
    model_rd = 32'h0000_CAFE;
    tick();

    // IO write to 0xF000_0008, immediate ack; read data unchanged
    ack_delay = 1;
    n0 = ready_count;
    do_req(1'b1, 32'hF000_0008, 32'h1111_2222, 1'b1, 1 + 1, model_rd, 1'b0);
    wait_ready(n0 + 1, 10);
    check("io_we_seen", {31'd0, io_we_seen}, 32'd1);
    check("io_wr_addr", {28'd0, last_io_addr}, 32'd2);
    check("io_wdata", last_io_wdata, 32'h1111_2222);
    tick();

    // Stray io_ack while idle is ignored
    n0 = ready_count;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    repeat (2) tick();
    check("stray_ack_ready", 32'(ready_count), 32'(n0));
    check("stray_ack_io_en", {31'd0, io_en}, 32'd0);

    // Ack on the last countable cycle completes normally in either build
    ack_delay = TIMEOUT;
    io_rdata  = 32'hBEEF_0001;
    n0 = ready_count;
    do_req(1'b0, 32'hE000_0000, 32'h0, 1'b1, 1 + TIMEOUT, 32'hBEEF_0001, 1'b0);
    wait_ready(n0 + 1, 40);
    model_rd = 32'hBEEF_0001;
    tick();

    // IO read with no ack at all
    ack_delay = 0;
    n0 = ready_count;
`ifdef MIO_TIMEOUT_EN
    do_req(1'b0, 32'hE000_000C, 32'h0, 1'b1, 1 + TIMEOUT, 32'hDEAD_BEEF, 1'b1);
    wait_ready(n0 + 1, 40);
    model_rd = 32'hDEAD_BEEF;
    tick();
    check("timeout_io_en_low", {31'd0, io_en}, 32'd0);
`else
    do_req(1'b0, 32'hE000_000C, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    repeat (25) tick();
    check("noack_no_ready", 32'(ready_count), 32'(n0));
    check("noack_io_en_held", {31'd0, io_en}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_rd = 32'h0;
    tick();
`endif

    // Reset in the middle of a peripheral access
    n0 = ready_count;
    do_req(1'b0, 32'hE000_0010, 32'h0, 1'b0, 0, 32'h0, 1'b0);
    repeat (2) tick();
    check("pre_rst_io_en", {31'd0, io_en}, 32'd1);
    rst = 1'b1;
    tick();
    check("abort_io_en", {31'd0, io_en}, 32'd0);
    check("abort_mio_ready", {31'd0, MIO_ready}, 32'd0);
    check("abort_cpu_rdata", cpu_rdata, 32'd0);
    rst = 1'b0;
    model_rd = 32'h0;
    tick();
    check("abort_no_ready", 32'(ready_count), 32'(n0));
    n0 = ready_count;
    do_req(1'b0, 32'h0000_0040, 32'h0, 1'b1, RAM_LAT, ram_val(10'd16), 1'b0);
    wait_ready(n0 + 1, 10);
    tick();

    // Back-to-back: CPU_MIO held high across two reads
    n0 = ready_count;
    CPU_MIO  = 1'b1;
    WR       = 1'b0;
    cpu_addr = 32'h0000_0100;
    push_exp(RAM_LAT, ram_val(10'd64), 1'b0);
    tick();                                  // first access in RAM_ACC
    cpu_addr = 32'h0000_0104;
    push_exp(2 + RAM_LAT, ram_val(10'd65), 1'b0); // DONE, IDLE, then the access
    tick();                                  // DONE
    tick();                                  // IDLE: second request accepted
    tick();
    CPU_MIO = 1'b0;
    wait_ready(n0 + 2, 20);
    tick();

    repeat (3) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
